// File: rtl/ascii_hex_pkg.sv
// rtl/ascii_hex_pkg.sv - shared constants, state and character-class encodings for the hex parser
package ascii_hex_pkg;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        EMIT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_DIGIT = 2'd0,
        CLS_TERM  = 2'd1,
        CLS_OTHER = 2'd2
    } cls_t;

endpackage

// File: rtl/ascii_to_nibble.sv
// rtl/ascii_to_nibble.sv - combinational ASCII classifier and hex digit decoder
// Optional lowercase digits: ASCII_HEX_LOWER_EN
module ascii_to_nibble
    import ascii_hex_pkg::*;
(
    input  logic [7:0] i_char,
    output logic [1:0] o_cls,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_cls    = CLS_OTHER;
        o_nibble = 4'h0;
        if (i_char >= 8'h30 && i_char <= 8'h39) begin
            o_cls    = CLS_DIGIT;
            o_nibble = i_char[3:0];
        end else if (i_char >= 8'h41 && i_char <= 8'h46) begin
            // 'A' is 0x41, so the low nibble plus 9 gives 10..15
            o_cls    = CLS_DIGIT;
            o_nibble = i_char[3:0] + 4'd9;
        end
`ifdef ASCII_HEX_LOWER_EN
        else if (i_char >= 8'h61 && i_char <= 8'h66) begin
            o_cls    = CLS_DIGIT;
            o_nibble = i_char[3:0] + 4'd9;
        end
`endif
        else if (i_char == CHAR_CR || i_char == CHAR_LF || i_char == CHAR_SP) begin
            o_cls = CLS_TERM;
        end
    end

endmodule

// File: rtl/ascii_hex_parser.sv
// rtl/ascii_hex_parser.sv - streaming ASCII hex token parser producing WIDTH-bit words
// Lowercase hex digits accepted when ASCII_HEX_LOWER_EN is defined (see ascii_to_nibble)
module ascii_hex_parser
    import ascii_hex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             char_valid,
    input  logic [7:0]       char_data,
    output logic             char_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    input  logic             out_ready
);

    localparam int DIGITS = WIDTH / 4;
    localparam int CNT_W  = $clog2(DIGITS + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_err;

    logic [1:0]       w_cls;
    logic [3:0]       w_nibble;
    logic             w_accept;
    logic [WIDTH-1:0] w_shifted;
    logic             w_full;

    ascii_to_nibble u_ascii_to_nibble (
        .i_char   (char_data),
        .o_cls    (w_cls),
        .o_nibble (w_nibble)
    );

    assign char_ready = (r_state != EMIT);
    assign w_accept   = char_valid && char_ready;
    // Shift form rather than a part-select so WIDTH = 4 stays legal
    assign w_shifted  = (r_acc << 4) | WIDTH'(w_nibble);
    assign w_full     = (r_cnt == CNT_W'(DIGITS));

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_err    = r_out_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_cls == CLS_DIGIT) begin
                            r_acc   <= WIDTH'(w_nibble);
                            r_cnt   <= CNT_W'(1);
                            r_state <= ACCUM;
                        end else if (w_cls != CLS_TERM) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        if (w_cls == CLS_DIGIT) begin
                            if (w_full) begin
                                r_state <= DRAIN;
                            end else begin
                                r_acc <= w_shifted;
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end else if (w_cls == CLS_TERM) begin
                            r_out_data  <= r_acc;
                            r_out_err   <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= EMIT;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_accept && w_cls == CLS_TERM) begin
                        r_out_data  <= '0;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_hex_parser.sv
// tb/tb_ascii_hex_parser.sv - directed self-checking bench for ascii_hex_parser
module tb_ascii_hex_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_err;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    int tok_count = 0;
    int tok0;
    logic [31:0] exp_lc_data;
    logic        exp_lc_err;

    ascii_hex_parser #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_err    (out_err),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) tok_count++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c);
        int n;
        n = 0;
        char_data  = c;
        char_valid = 1'b1;
        while (!char_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("ready_timeout", {63'd0, char_ready}, 64'd1);
        step();
        char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    initial begin
`ifdef ASCII_HEX_LOWER_EN
        exp_lc_data = 32'hCD;
        exp_lc_err  = 1'b0;
`else
        exp_lc_data = 32'h0;
        exp_lc_err  = 1'b1;
`endif
        rst        = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        out_ready  = 1'b1;
        step();
        step();
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_data",  {32'd0, out_data},  64'd0);
        check("rst_err",   {63'd0, out_err},   64'd0);
        rst = 1'b0;
        step();
        check("rst_ready", {63'd0, char_ready}, 64'd1);

        // Full-width token
        send_str("1A2B3C4D");
        send_char(8'h0D);
        check("t1_valid", {63'd0, out_valid}, 64'd1);
        check("t1_data",  {32'd0, out_data},  64'h1A2B3C4D);
        check("t1_err",   {63'd0, out_err},   64'd0);
        check("t1_ready", {63'd0, char_ready}, 64'd0);
        step();
        check("t1_one_cycle", {63'd0, out_valid}, 64'd0);
        check("t1_ready_back", {63'd0, char_ready}, 64'd1);

        // Single digit with space, then a bare LF
        tok0 = tok_count;
        send_str("F ");
        check("t2_valid", {63'd0, out_valid}, 64'd1);
        check("t2_data",  {32'd0, out_data},  64'hF);
        check("t2_err",   {63'd0, out_err},   64'd0);
        step();
        send_char(8'h0A);
        step();
        step();
        check("t2_lf_novalid", {63'd0, out_valid}, 64'd0);
        check("t2_tokens", 64'(tok_count - tok0), 64'd1);

        // Bad character, then recovery
        send_str("12G4");
        send_char(8'h0D);
        check("t3_valid", {63'd0, out_valid}, 64'd1);
        check("t3_err",   {63'd0, out_err},   64'd1);
        check("t3_data",  {32'd0, out_data},  64'd0);
        step();
        send_str("7");
        send_char(8'h0D);
        check("t3b_valid", {63'd0, out_valid}, 64'd1);
        check("t3b_data",  {32'd0, out_data},  64'h7);
        check("t3b_err",   {63'd0, out_err},   64'd0);
        step();

        // Nine digits overflow a 32-bit word
        send_str("123456789");
        send_char(8'h0D);
        check("t4_valid", {63'd0, out_valid}, 64'd1);
        check("t4_err",   {63'd0, out_err},   64'd1);
        check("t4_data",  {32'd0, out_data},  64'd0);
        step();

        // Output back-pressure
        out_ready = 1'b0;
        send_str("AB");
        send_char(8'h0D);
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_valid", {63'd0, out_valid}, 64'd1);
            check("t5_hold_ready", {63'd0, char_ready}, 64'd0);
            check("t5_hold_data",  {32'd0, out_data},  64'hAB);
            step();
        end
        out_ready = 1'b1;
        step();
        check("t5_release_valid", {63'd0, out_valid}, 64'd0);
        check("t5_release_ready", {63'd0, char_ready}, 64'd1);

        // Reset mid-token discards it
        tok0 = tok_count;
        send_str("AB");
        rst = 1'b1;
        #2;
        check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
        step();
        rst = 1'b0;
        step();
        send_char(8'h0D);
        step();
        step();
        check("t6_no_valid", {63'd0, out_valid}, 64'd0);
        check("t6_tokens", 64'(tok_count - tok0), 64'd0);

        // Lowercase digits depend on configuration
        send_str("cd");
        send_char(8'h0D);
        check("t7_valid", {63'd0, out_valid}, 64'd1);
        check("t7_data",  {32'd0, out_data},  {32'd0, exp_lc_data});
        check("t7_err",   {63'd0, out_err},   {63'd0, exp_lc_err});
        step();
        check("t7_done", {63'd0, out_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
